l2_flush_walker: RTL and testbench

L2_FLUSH_WALKER -- requirements
Module: l2_flush_walker

---
 rtl/l2_flush_walker.sv | 149 ++++++++++++++
 tb/tb_l2_flush_walker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_flush_walker.sv
// L2 flush walker: steps (set, way) over the whole cache, plus conflict/stall flags.
// Optional L2_FLUSH_SKIP_EN adds skip_set to jump to way 0 of the next set.
`ifndef REQS_BITS
`define REQS_BITS 4
`endif

module l2_flush_walker #(
  parameter int SETS  = 256,
  parameter int WAYS  = 8,
  parameter int CH    = 2,
  parameter int IDX_W = `REQS_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_start,
  input  logic                     flush_abort,
  input  logic                     step,
`ifdef L2_FLUSH_SKIP_EN
  input  logic                     skip_set,
`endif
  output logic                     flush_active,
  output logic [$clog2(SETS)-1:0]  flush_set,
  output logic [$clog2(WAYS)-1:0]  flush_way,
  output logic                     flush_last,
  output logic                     flush_done,
  input  logic                     set_set_conflict,
  input  logic                     clr_set_conflict,
  output logic                     set_conflict,
  input  logic [CH-1:0]            set_fwd_stall,
  input  logic [CH-1:0]            clr_fwd_stall,
  output logic [CH-1:0]            fwd_stall,
  output logic                     fwd_stall_any,
  input  logic [CH-1:0]            fwd_stall_i_we,
  input  logic [CH*IDX_W-1:0]      fwd_stall_i_wr_data,
  output logic [CH*IDX_W-1:0]      fwd_stall_i
);

  localparam int SW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);
  localparam logic [SW-1:0] SET_MAX = SW'(SETS - 1);
  localparam logic [WW-1:0] WAY_MAX = WW'(WAYS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] set_q, set_d;
  logic [WW-1:0] way_q, way_d;
  logic          skip;

`ifdef L2_FLUSH_SKIP_EN
  assign skip = skip_set;
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      set_q   <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
    end
  end

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    unique case (state_q)
      IDLE: begin
        if (flush_start) begin
          state_d = WALK;
          set_d   = '0;
          way_d   = '0;
        end
      end
      WALK: begin
        if (flush_abort) begin
          state_d = IDLE;
          set_d   = '0;
          way_d   = '0;
        end else if (step) begin
          // A skip behaves like stepping off the last way of the set
          if (skip || way_q == WAY_MAX) begin
            way_d = '0;
            if (set_q == SET_MAX) begin
              state_d = DONE;
              set_d   = '0;
            end else begin
              set_d = set_q + 1'b1;
            end
          end else begin
            way_d = way_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign flush_active = (state_q == WALK);
  assign flush_done   = (state_q == DONE);
  assign flush_set    = set_q;
  assign flush_way    = way_q;
  assign flush_last   = flush_active &&
                        set_q == SET_MAX &&
                        way_q == WAY_MAX;

  logic          conflict_q;
  logic [CH-1:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      if (clr_set_conflict)
        conflict_q <= 1'b0;
      else if (set_set_conflict)
        conflict_q <= 1'b1;
      stall_q <= (stall_q | set_fwd_stall) & ~clr_fwd_stall;
    end
  end

  assign set_conflict  = conflict_q;
  assign fwd_stall     = stall_q;
  assign fwd_stall_any = |stall_q;

  logic [IDX_W-1:0] idx_q [CH];

  for (genvar c = 0; c < CH; c++) begin : g_idx
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        idx_q[c] <= '0;
      else if (fwd_stall_i_we[c])
        idx_q[c] <= fwd_stall_i_wr_data[c*IDX_W +: IDX_W];
    end
    assign fwd_stall_i[c*IDX_W +: IDX_W] = idx_q[c];
  end

endmodule

// File: tb/tb_l2_flush_walker.sv
// Self-checking bench for l2_flush_walker (SETS=4, WAYS=2, CH=2, IDX_W=4).
// Vector table for flags/indices, directed walk sequences, random run vs model.
module tb_l2_flush_walker;

  localparam int SETS  = 4;
  localparam int WAYS  = 2;
  localparam int CH    = 2;
  localparam int IDX_W = 4;
  localparam int LINES = SETS * WAYS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush_start = 0, flush_abort = 0, step = 0;
  logic skip_set = 0;
  logic flush_active, flush_last, flush_done;
  logic [1:0] flush_set;
  logic [0:0] flush_way;
  logic set_set_conflict = 0, clr_set_conflict = 0, set_conflict;
  logic [CH-1:0] set_fwd_stall = 0, clr_fwd_stall = 0, fwd_stall;
  logic fwd_stall_any;
  logic [CH-1:0] fwd_stall_i_we = 0;
  logic [CH*IDX_W-1:0] fwd_stall_i_wr_data = 0, fwd_stall_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_flush_walker #(
    .SETS(SETS), .WAYS(WAYS), .CH(CH), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst),
    .flush_start(flush_start), .flush_abort(flush_abort), .step(step),
`ifdef L2_FLUSH_SKIP_EN
    .skip_set(skip_set),
`endif
    .flush_active(flush_active), .flush_set(flush_set),
    .flush_way(flush_way), .flush_last(flush_last),
    .flush_done(flush_done),
    .set_set_conflict(set_set_conflict),
    .clr_set_conflict(clr_set_conflict),
    .set_conflict(set_conflict),
    .set_fwd_stall(set_fwd_stall), .clr_fwd_stall(clr_fwd_stall),
    .fwd_stall(fwd_stall), .fwd_stall_any(fwd_stall_any),
    .fwd_stall_i_we(fwd_stall_i_we),
    .fwd_stall_i_wr_data(fwd_stall_i_wr_data),
    .fwd_stall_i(fwd_stall_i)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_walk(string tag, logic a, int s, int w, logic l, logic d);
    chk({tag, ".active"}, 32'(flush_active), 32'(a));
    chk({tag, ".set"}, 32'(flush_set), 32'(s));
    chk({tag, ".way"}, 32'(flush_way), 32'(w));
    chk({tag, ".last"}, 32'(flush_last), 32'(l));
    chk({tag, ".done"}, 32'(flush_done), 32'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    flush_start = 0; flush_abort = 0; step = 0; skip_set = 0;
    set_set_conflict = 0; clr_set_conflict = 0;
    set_fwd_stall = 0; clr_fwd_stall = 0;
    fwd_stall_i_we = 0; fwd_stall_i_wr_data = 0;
  endtask

  task automatic do_reset();
    clear_in();
    #2 rst = 1'b0;
    #1;
    chk_walk("rst", 0, 0, 0, 0, 0);
    chk("rst.conflict", 32'(set_conflict), 0);
    chk("rst.stall", 32'(fwd_stall), 0);
    chk("rst.any", 32'(fwd_stall_any), 0);
    chk("rst.idx", 32'(fwd_stall_i), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  typedef struct {
    logic sc, cc;
    logic [1:0] sf, cf, we;
    logic [7:0] wd;
    logic e_c;
    logic [1:0] e_f;
    logic e_any;
    logic [7:0] e_idx;
  } vec_t;

  vec_t vt[6];

  // behavioural model state for the random run
  int m_lin;
  bit m_act, m_done, m_conf;
  logic [1:0] m_stall;
  logic [3:0] m_idx[CH];

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1, 0, 2'b11, 2'b01, 2'b10, 8'h31, 1, 2'b10, 1, 8'h30};
    vt[1] = '{1, 1, 2'b00, 2'b00, 2'b01, 8'h57, 0, 2'b10, 1, 8'h37};
    vt[2] = '{0, 0, 2'b01, 2'b10, 2'b00, 8'hff, 0, 2'b01, 1, 8'h37};
    vt[3] = '{1, 0, 2'b11, 2'b11, 2'b11, 8'ha5, 1, 2'b00, 0, 8'ha5};
    vt[4] = '{0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 1, 2'b00, 0, 8'ha5};
    vt[5] = '{0, 1, 2'b10, 2'b00, 2'b10, 8'h9c, 0, 2'b10, 1, 8'h95};

    #3;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      set_set_conflict = vt[i].sc; clr_set_conflict = vt[i].cc;
      set_fwd_stall = vt[i].sf; clr_fwd_stall = vt[i].cf;
      fwd_stall_i_we = vt[i].we; fwd_stall_i_wr_data = vt[i].wd;
      tick();
      chk($sformatf("vec%0d.conflict", i), 32'(set_conflict), 32'(vt[i].e_c));
      chk($sformatf("vec%0d.stall", i), 32'(fwd_stall), 32'(vt[i].e_f));
      chk($sformatf("vec%0d.any", i), 32'(fwd_stall_any), 32'(vt[i].e_any));
      chk($sformatf("vec%0d.idx", i), 32'(fwd_stall_i), 32'(vt[i].e_idx));
    end
    clear_in();

    // full walk
    flush_start = 1; tick(); flush_start = 0;
    for (int i = 0; i < LINES; i++) begin
      chk_walk($sformatf("walk%0d", i), 1, i / WAYS, i % WAYS, i == LINES - 1, 0);
      step = 1; flush_start = (i == 3); tick();
    end
    step = 0; flush_start = 0;
    chk_walk("walk.done", 0, 0, 0, 0, 1);
    tick();
    chk_walk("walk.idle", 0, 0, 0, 0, 0);

    // abort together with step at (2,1)
    flush_start = 1; tick(); flush_start = 0;
    step = 1;
    repeat (5) tick();
    chk_walk("abort.pre", 1, 2, 1, 0, 0);
    flush_abort = 1; tick();
    flush_abort = 0; step = 0;
    chk_walk("abort.post", 0, 0, 0, 0, 0);
    tick();
    chk_walk("abort.nodone", 0, 0, 0, 0, 0);

    // reset mid-walk at (1,1), flags loaded first
    set_set_conflict = 1; set_fwd_stall = 2'b11;
    fwd_stall_i_we = 2'b11; fwd_stall_i_wr_data = 8'h7e;
    flush_start = 1; tick(); clear_in();
    step = 1; repeat (3) tick(); step = 0;
    chk_walk("midrst.pre", 1, 1, 1, 0, 0);
    do_reset();
    chk_walk("midrst.after", 0, 0, 0, 0, 0);
    flush_start = 1; tick(); flush_start = 0;
    chk_walk("midrst.restart", 1, 0, 0, 0, 0);
    flush_abort = 1; tick(); flush_abort = 0;

`ifdef L2_FLUSH_SKIP_EN
    flush_start = 1; tick(); flush_start = 0;
    step = 1; repeat (2) tick();
    chk_walk("skip.pre", 1, 1, 0, 0, 0);
    skip_set = 1; tick();
    chk_walk("skip.next", 1, 2, 0, 0, 0);
    tick();
    chk_walk("skip.s3", 1, 3, 0, 0, 0);
    tick();
    step = 0; skip_set = 0;
    chk_walk("skip.done", 0, 0, 0, 0, 1);
    tick();
`endif

    // random run against the model
    do_reset();
    m_lin = 0; m_act = 0; m_done = 0; m_conf = 0; m_stall = 0;
    for (int c = 0; c < CH; c++) m_idx[c] = 0;
    for (int n = 0; n < 600; n++) begin
      flush_start = ($urandom % 4) == 0;
      flush_abort = ($urandom % 16) == 0;
      step = ($urandom % 4) != 0;
      set_set_conflict = $urandom; clr_set_conflict = $urandom;
      set_fwd_stall = 2'($urandom); clr_fwd_stall = 2'($urandom);
      fwd_stall_i_we = 2'($urandom); fwd_stall_i_wr_data = 8'($urandom);
      @(posedge clk);
      if (m_done) m_done = 0;
      else if (!m_act) begin
        if (flush_start) begin m_act = 1; m_lin = 0; end
      end else if (flush_abort) begin
        m_act = 0; m_lin = 0;
      end else if (step) begin
        if (m_lin == LINES - 1) begin m_act = 0; m_done = 1; m_lin = 0; end
        else m_lin++;
      end
      if (clr_set_conflict) m_conf = 0;
      else if (set_set_conflict) m_conf = 1;
      for (int c = 0; c < CH; c++) begin
        if (clr_fwd_stall[c]) m_stall[c] = 0;
        else if (set_fwd_stall[c]) m_stall[c] = 1;
        if (fwd_stall_i_we[c]) m_idx[c] = fwd_stall_i_wr_data[c*IDX_W +: IDX_W];
      end
      #1;
      chk_walk("rnd", m_act, m_lin / WAYS, m_lin % WAYS,
               m_act && m_lin == LINES - 1, m_done);
      chk("rnd.conflict", 32'(set_conflict), 32'(m_conf));
      chk("rnd.stall", 32'(fwd_stall), 32'(m_stall));
      chk("rnd.any", 32'(fwd_stall_any), 32'(m_stall != 0));
      chk("rnd.idx", 32'(fwd_stall_i), 32'({m_idx[1], m_idx[0]}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
